// File: rtl/pe_pkg.sv
// Shared types and sizing constants for the row-stationary PE MAC sequencer.
package pe_pkg;

    localparam int DEF_IN_BITWIDTH  = 16;
    localparam int DEF_OUT_BITWIDTH = 32;
    localparam int MAX_FILT_LEN     = 8;
    localparam int TAP_W            = $clog2(MAX_FILT_LEN);
    // The fill counter must also hold FILT_LEN itself, hence one extra bit.
    localparam int NEED_W           = $clog2(MAX_FILT_LEN + 1);

    typedef enum logic [2:0] {
        W_LOAD,
        A_FILL,
        COMPUTE,
        DRAIN,
        EMIT
    } seq_state_t;

endpackage : pe_pkg

// File: rtl/pe_mac_sequencer_if.sv
// Bundle of weight/activation/psum handshakes and the MAC drive/return signals.
interface pe_mac_sequencer_if #(
    parameter int IN_BITWIDTH  = pe_pkg::DEF_IN_BITWIDTH,
    parameter int OUT_BITWIDTH = pe_pkg::DEF_OUT_BITWIDTH
) ();

    logic [IN_BITWIDTH-1:0]  w_data;
    logic                    w_valid;
    logic                    w_ready;
    logic                    wt_reload;

    logic [IN_BITWIDTH-1:0]  a_data;
    logic                    a_last;
    logic                    a_valid;
    logic                    a_ready;

    logic [IN_BITWIDTH-1:0]  psum_in;
    logic                    psum_in_valid;
    logic                    psum_in_ready;

    logic [IN_BITWIDTH-1:0]  mac_a;
    logic [IN_BITWIDTH-1:0]  mac_w;
    logic [IN_BITWIDTH-1:0]  mac_sum;
    logic                    mac_en;
    logic [OUT_BITWIDTH-1:0] mac_out;

    logic [OUT_BITWIDTH-1:0] psum_out;
    logic                    psum_out_valid;
    logic                    psum_out_ready;

    // Sequencer side.
    modport slave (
        input  w_data, w_valid, wt_reload,
        input  a_data, a_last, a_valid,
        input  psum_in, psum_in_valid,
        input  mac_out, psum_out_ready,
        output w_ready, a_ready, psum_in_ready,
        output mac_a, mac_w, mac_sum, mac_en,
        output psum_out, psum_out_valid
    );

    // Environment side: producers, MAC unit and psum consumer.
    modport master (
        output w_data, w_valid, wt_reload,
        output a_data, a_last, a_valid,
        output psum_in, psum_in_valid,
        output mac_out, psum_out_ready,
        input  w_ready, a_ready, psum_in_ready,
        input  mac_a, mac_w, mac_sum, mac_en,
        input  psum_out, psum_out_valid
    );

endinterface : pe_mac_sequencer_if

// File: rtl/pe_shift_spad.sv
// DEPTH-entry shift register scratchpad: new words enter at the top index,
// older words move toward index 0; any entry is readable by index.
module pe_shift_spad #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[DEPTH-1] = din;
        end
    end

    // NOTE: storage is deliberately not reset; every entry is rewritten
    // before it is read, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_idx];

endmodule : pe_shift_spad

// File: rtl/pe_mac_sequencer.sv
// Row-stationary PE control: holds a weight row, slides an activation window,
// issues FILT_LEN MAC ops per output and emits the accumulated psum.
module pe_mac_sequencer
    import pe_pkg::*;
#(
    parameter int IN_BITWIDTH  = DEF_IN_BITWIDTH,
    parameter int OUT_BITWIDTH = DEF_OUT_BITWIDTH,
    parameter int FILT_LEN     = 3
) (
    input logic              clk,
    input logic              rst_n,
    pe_mac_sequencer_if.slave bus
);

    localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(FILT_LEN - 1);
    localparam logic [NEED_W-1:0] NEED_FULL = NEED_W'(FILT_LEN);

    seq_state_t state_q, state_d;
    logic [TAP_W-1:0]        w_cnt_q, w_cnt_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [NEED_W-1:0]       need_q, need_d;
    logic                    row_end_q, row_end_d;
    logic [OUT_BITWIDTH-1:0] acc_q, acc_d;
    // Tracks which tap the MAC result arriving this cycle belongs to.
    logic                    issued_q, issued_d;
    logic                    issued_first_q, issued_first_d;

    logic [IN_BITWIDTH-1:0]  w_spad_q [FILT_LEN];
    logic [IN_BITWIDTH-1:0]  w_spad_d [FILT_LEN];
    logic                    w_we;
    logic                    a_shift;
    logic [IN_BITWIDTH-1:0]  win_rd;

    pe_shift_spad #(
        .WIDTH (IN_BITWIDTH),
        .DEPTH (FILT_LEN),
        .IDX_W (TAP_W)
    ) u_window (
        .clk      (clk),
        .shift_en (a_shift),
        .din      (bus.a_data),
        .rd_idx   (tap_q),
        .rd_data  (win_rd)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d            = state_q;
        w_cnt_d            = w_cnt_q;
        tap_d              = tap_q;
        need_d             = need_q;
        row_end_d          = row_end_q;
        w_we               = 1'b0;
        a_shift            = 1'b0;
        bus.w_ready        = 1'b0;
        bus.a_ready        = 1'b0;
        bus.psum_in_ready  = 1'b0;
        bus.mac_en         = 1'b0;
        bus.mac_a          = '0;
        bus.mac_w          = '0;
        bus.mac_sum        = '0;
        bus.psum_out       = '0;
        bus.psum_out_valid = 1'b0;

        case (state_q)
            W_LOAD: begin
                bus.w_ready = 1'b1;
                if (bus.w_valid) begin
                    w_we = 1'b1;
                    if (w_cnt_q == LAST_TAP) begin
                        w_cnt_d = '0;
                        need_d  = NEED_FULL;
                        state_d = A_FILL;
                    end else begin
                        w_cnt_d = w_cnt_q + 1'b1;
                    end
                end
            end

            A_FILL: begin
                bus.a_ready = (need_q != '0);
                if (need_q != '0) begin
                    if (bus.a_valid) begin
                        // The last word shifted in decides row_end, so an early
                        // a_last is simply overwritten and the row keeps going.
                        a_shift   = 1'b1;
                        need_d    = need_q - 1'b1;
                        row_end_d = bus.a_last;
                    end
                end else if (bus.psum_in_valid) begin
                    tap_d   = '0;
                    state_d = COMPUTE;
                end
            end

            COMPUTE: begin
                bus.mac_en        = 1'b1;
                bus.mac_a         = win_rd;
                bus.mac_w         = w_spad_q[tap_q];
                bus.psum_in_ready = (tap_q == '0);
                if (tap_q == '0) begin
                    bus.mac_sum = bus.psum_in;
                end
                tap_d = tap_q + 1'b1;
                if (tap_q == LAST_TAP) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                state_d = EMIT;
            end

            EMIT: begin
                bus.psum_out       = acc_q;
                bus.psum_out_valid = 1'b1;
                if (bus.psum_out_ready) begin
                    if (!row_end_q) begin
                        need_d  = NEED_W'(1);
                        state_d = A_FILL;
                    end else if (bus.wt_reload) begin
                        w_cnt_d = '0;
                        state_d = W_LOAD;
                    end else begin
                        need_d  = NEED_FULL;
                        state_d = A_FILL;
                    end
                end
            end

            default: state_d = W_LOAD;
        endcase
    end

    always_comb begin
        issued_d       = bus.mac_en;
        issued_first_d = bus.mac_en && (tap_q == '0);
        acc_d          = acc_q;
        if (issued_q) begin
            acc_d = issued_first_q ? bus.mac_out : acc_q + bus.mac_out;
        end
    end

    always_comb begin
        w_spad_d = w_spad_q;
        if (w_we) begin
            w_spad_d[w_cnt_q] = bus.w_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= W_LOAD;
            w_cnt_q        <= '0;
            tap_q          <= '0;
            need_q         <= '0;
            row_end_q      <= 1'b0;
            acc_q          <= '0;
            issued_q       <= 1'b0;
            issued_first_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            w_cnt_q        <= w_cnt_d;
            tap_q          <= tap_d;
            need_q         <= need_d;
            row_end_q      <= row_end_d;
            acc_q          <= acc_d;
            issued_q       <= issued_d;
            issued_first_q <= issued_first_d;
        end
    end

    always_ff @(posedge clk) begin
        w_spad_q <= w_spad_d;
    end

endmodule : pe_mac_sequencer
